mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Next-generation multicycle RV32I control FSM. It adds four things:
//  - mem_ready wait-state handshake on fetch, load and store;
//  - JALR support;
//  - trap state for illegal opcodes and bus timeouts;
//  - optional performance counters.
//  Sits between IR/decoder and datapath muxes, ALU, regfile, PC and memory.
// PARAMETERS
//  TIMEOUT_CYC  15  wait cycles without mem_ready before bus trap; 0 = never time out
//  TO_W         4   width of wait counter; must hold TIMEOUT_CYC
//  CNT_W        32  width of performance counters
// PORTS
//  clock         in   1      system clock, all state on rising edge
//  reset         in   1      synchronous, active-high
//  opcode        in   5      instr[6:2]
//  Flag          in   1      ALU branch-condition result (1 = taken)
//  mem_ready     in   1      memory completes current access this cycle
//  ALU_Op        out  2      00 none, 01 add (address), 10 arith per funct, 11 branch compare
//  operand_sel   out  1      ALU B: 0 = regfile, 1 = immediate
//  wrt_en        out  1      regfile write enable
//  wrt_add_sel   out  1      regfile write address: 0 = rd field (always 0 in this block)
//  wrt_data_sel  out  3      000 ALU, 001 mem data, 010 imm_U, 011 PC+imm, 100 PC+4
//  branch        out  2      next PC: 00 PC+4, 01 PC+Bimm, 10 PC+Jimm, 11 ALU result & ~1
//  PC_Write      out  1      PC load enable
//  IR_Write      out  1      instruction register load enable
//  Mem_rd        out  1      memory read request
//  Mem_wr        out  1      memory write request
//  IorD          out  1      memory address: 1 = PC, 0 = ALU_Out
//  trap          out  1      sticky trap indication
//  trap_cause    out  2      00 none, 01 illegal opcode, 10 bus timeout
//  state_o       out  4      present state, for debug
//  cycle_cnt     out  CNT_W  performance counter, see CONFIGURATION
//  retire_cnt    out  CNT_W  performance counter, see CONFIGURATION
// BEHAVIOUR
//  - While reset=1, all outputs are 0.
//  - At the first clock edge with reset=1: state <= IF, wait counter <= 0, trap_cause <= 00.
//  - Outputs are decoded combinationally from present_state, Flag and mem_ready.
//  - Any output not listed for a state is 0.
//  - States, with state_o encoding:
//    IF=0, ID=1, EX_S=2, EX_R=3, EX_I=4, EX_B=5, EX_J=6, MEM_LD=7, MEM_ST=8,
//    WB_LD=9, WB_REG=10, WB_UI=11, EX_JR=12, TRAP=13.
//  - IF: Mem_rd=1, IorD=1. Holds while mem_ready=0. When mem_ready=1: IR_Write=1, then -> ID.
//  - ID: decode only.
//    - 01100 -> EX_R; 00100 -> EX_I; 00000 and 01000 -> EX_S; 11000 -> EX_B
//    - 11011 -> EX_J; 11001 -> EX_JR; 01101 and 00101 -> WB_UI
//    - any other opcode -> TRAP with cause 01
//  - EX_R: ALU_Op=10, operand_sel=0 -> WB_REG.
//  - EX_I: ALU_Op=10, operand_sel=1 -> WB_REG.
//  - EX_S: ALU_Op=01, operand_sel=1. Opcode 00000 -> MEM_LD, otherwise -> MEM_ST.
//  - EX_B: ALU_Op=11, PC_Write=1, branch=Flag?01:00 -> IF.
//  - EX_J: wrt_en=1, wrt_data_sel=100, branch=10, PC_Write=1 -> IF.
//  - EX_JR: ALU_Op=01, operand_sel=1, wrt_en=1, wrt_data_sel=100, branch=11, PC_Write=1 -> IF.
//    Link value is the old PC+4, even when rs1==rd.
//  - MEM_LD: Mem_rd=1, IorD=0. Holds until mem_ready=1, then -> WB_LD.
//  - MEM_ST: Mem_wr=1, IorD=0. Holds until mem_ready=1.
//    PC_Write=1 only in the mem_ready cycle, then -> IF.
//  - WB_LD: wrt_en=1, wrt_data_sel=001, PC_Write=1 -> IF.
//  - WB_REG: wrt_en=1, wrt_data_sel=000, PC_Write=1 -> IF.
//  - WB_UI: wrt_en=1, PC_Write=1, wrt_data_sel = LUI(01101)?010:011 -> IF.
//  - TRAP: trap=1, all other controls 0. Absorbing until reset.
//  - Wait counter:
//    - increments each cycle in IF, MEM_LD or MEM_ST with mem_ready=0; clears on any state change
//    - if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with mem_ready=0 -> TRAP, cause 10
//    - mem_ready=1 in that same cycle wins: normal transition
//  - mem_ready outside IF, MEM_LD and MEM_ST is ignored.
//  - Reset mid-access: the request drops in the reset cycle; no PC_Write or IR_Write is issued.
// CONFIGURATION
//  MC_FSM_PERF_CNT_EN defined:
//   - cycle_cnt +1 every cycle with reset=0
//   - retire_cnt +1 every cycle with PC_Write=1
//   - both clear on reset and wrap modulo 2^CNT_W
//  MC_FSM_PERF_CNT_EN undefined:
//   - both ports are present and tied to 0; no counter flops
// TESTING
//  1. ADD, opcode 01100, mem_ready=1 always -> IF, ID, EX_R, WB_REG.
//     4 cycles; wrt_en=1 and PC_Write=1 only in cycle 4; retire_cnt=1.
//  2. LW with mem_ready low 3 cycles in MEM_LD -> Mem_rd held 4 cycles, then WB_LD.
//     WB_LD gives wrt_data_sel=001.
//  3. BEQ with Flag=1 and then Flag=0 -> EX_B with branch=01 and 00; PC_Write=1 in both.
//  4. JALR, opcode 11001 -> EX_JR: branch=11, wrt_data_sel=100, wrt_en=1, PC_Write=1 in one cycle.
//  5. opcode 11111 -> TRAP, cause 01, trap sticky. mem_ready toggling has no effect.
//     reset clears the trap; state_o=0.
//  6. Fetch with mem_ready=0 for 15 cycles (TIMEOUT_CYC=15) -> TRAP, cause 10.
//     Repeat with mem_ready=1 in the 15th cycle -> ID, no trap.
//  7. Store with reset asserted mid-MEM_ST -> Mem_wr=0 in the reset cycle and no PC_Write;
//     IF after release.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with a mem_ready wait-state handshake, JALR,
// a sticky trap state (illegal opcode / bus timeout) and optional
// performance counters enabled by defining MC_FSM_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned TO_W        = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic             Flag,
    input  logic             mem_ready,
    output logic [1:0]       ALU_Op,
    output logic             operand_sel,
    output logic             wrt_en,
    output logic             wrt_add_sel,
    output logic [2:0]       wrt_data_sel,
    output logic [1:0]       branch,
    output logic             PC_Write,
    output logic             IR_Write,
    output logic             Mem_rd,
    output logic             Mem_wr,
    output logic             IorD,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_S   = 4'd2,
        S_EX_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_EX_B   = 4'd5,
        S_EX_J   = 4'd6,
        S_MEM_LD = 4'd7,
        S_MEM_ST = 4'd8,
        S_WB_LD  = 4'd9,
        S_WB_REG = 4'd10,
        S_WB_UI  = 4'd11,
        S_EX_JR  = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_ARITH = 5'b01100;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_BUS = 2'b10;

    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);

    state_t          state, next_state;
    logic [1:0]      cause_q, next_cause;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            timeout;

    // Next-state, trap cause and bus-timeout detection
    always_comb begin
        next_state = state;
        next_cause = cause_q;
        waiting    = 1'b0;
        case (state)
            S_IF: begin
                waiting = 1'b1;
                if (mem_ready) next_state = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_ARITH:           next_state = S_EX_R;
                    OP_IMM:             next_state = S_EX_I;
                    OP_LOAD, OP_STORE:  next_state = S_EX_S;
                    OP_BR:              next_state = S_EX_B;
                    OP_JAL:             next_state = S_EX_J;
                    OP_JALR:            next_state = S_EX_JR;
                    OP_LUI, OP_AUIPC:   next_state = S_WB_UI;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_ILL;
                    end
                endcase
            end
            S_EX_R, S_EX_I: next_state = S_WB_REG;
            S_EX_S:         next_state = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD: begin
                waiting = 1'b1;
                if (mem_ready) next_state = S_WB_LD;
            end
            S_MEM_ST: begin
                waiting = 1'b1;
                if (mem_ready) next_state = S_IF;
            end
            S_EX_B, S_EX_J, S_EX_JR,
            S_WB_LD, S_WB_REG, S_WB_UI: next_state = S_IF;
            S_TRAP:         next_state = S_TRAP;
            default:        next_state = S_IF;
        endcase
        // A completing access in the last allowed cycle still wins over the timeout
        timeout = (TIMEOUT_CYC != 0) && waiting && !mem_ready && (wait_cnt == TO_LAST);
        if (timeout) begin
            next_state = S_TRAP;
            next_cause = CAUSE_BUS;
        end
    end

    // State, trap cause and wait counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IF;
            cause_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state   <= next_state;
            cause_q <= next_cause;
            if (next_state != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Control decode from present state; everything forced low during reset
    always_comb begin
        ALU_Op       = '0;
        operand_sel  = 1'b0;
        wrt_en       = 1'b0;
        wrt_add_sel  = 1'b0;
        wrt_data_sel = '0;
        branch       = '0;
        PC_Write     = 1'b0;
        IR_Write     = 1'b0;
        Mem_rd       = 1'b0;
        Mem_wr       = 1'b0;
        IorD         = 1'b0;
        trap         = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    Mem_rd   = 1'b1;
                    IorD     = 1'b1;
                    IR_Write = mem_ready;
                end
                S_EX_R: ALU_Op = 2'b10;
                S_EX_I: begin
                    ALU_Op      = 2'b10;
                    operand_sel = 1'b1;
                end
                S_EX_S: begin
                    ALU_Op      = 2'b01;
                    operand_sel = 1'b1;
                end
                S_EX_B: begin
                    ALU_Op   = 2'b11;
                    PC_Write = 1'b1;
                    branch   = Flag ? 2'b01 : 2'b00;
                end
                S_EX_J: begin
                    wrt_en       = 1'b1;
                    wrt_data_sel = 3'b100;
                    branch       = 2'b10;
                    PC_Write     = 1'b1;
                end
                // Link is PC+4 from the unmodified PC, so rs1==rd is safe
                S_EX_JR: begin
                    ALU_Op       = 2'b01;
                    operand_sel  = 1'b1;
                    wrt_en       = 1'b1;
                    wrt_data_sel = 3'b100;
                    branch       = 2'b11;
                    PC_Write     = 1'b1;
                end
                S_MEM_LD: Mem_rd = 1'b1;
                S_MEM_ST: begin
                    Mem_wr   = 1'b1;
                    PC_Write = mem_ready;
                end
                S_WB_LD: begin
                    wrt_en       = 1'b1;
                    wrt_data_sel = 3'b001;
                    PC_Write     = 1'b1;
                end
                S_WB_REG: begin
                    wrt_en   = 1'b1;
                    PC_Write = 1'b1;
                end
                S_WB_UI: begin
                    wrt_en       = 1'b1;
                    PC_Write     = 1'b1;
                    wrt_data_sel = (opcode == OP_LUI) ? 3'b010 : 3'b011;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o    = reset ? '0 : state;
    assign trap_cause = reset ? '0 : cause_q;

`ifdef MC_FSM_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, retire_q;

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (PC_Write) retire_q <= retire_q + 1'b1;
        end
    end

    assign cycle_cnt  = reset ? '0 : cycle_q;
    assign retire_cnt = reset ? '0 : retire_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm (default parameters).
module tb_mc_ctrl_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic        Flag;
    logic        mem_ready;
    logic [1:0]  ALU_Op;
    logic        operand_sel, wrt_en, wrt_add_sel;
    logic [2:0]  wrt_data_sel;
    logic [1:0]  branch;
    logic        PC_Write, IR_Write, Mem_rd, Mem_wr, IorD, trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, retire_cnt;
    logic [15:0] ctl;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clock = ~clock;

    mc_ctrl_fsm #(.TIMEOUT_CYC(15), .TO_W(4), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .Flag(Flag),
        .mem_ready(mem_ready), .ALU_Op(ALU_Op), .operand_sel(operand_sel),
        .wrt_en(wrt_en), .wrt_add_sel(wrt_add_sel), .wrt_data_sel(wrt_data_sel),
        .branch(branch), .PC_Write(PC_Write), .IR_Write(IR_Write),
        .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .IorD(IorD), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    assign ctl = {ALU_Op, operand_sel, wrt_en, wrt_add_sel, wrt_data_sel, branch,
                  PC_Write, IR_Write, Mem_rd, Mem_wr, IorD, trap};

    // Expected control word from hand-chosen field values
    function automatic logic [15:0] mk(input logic [1:0] alu, input logic os,
                                       input logic we, input logic [2:0] wds,
                                       input logic [1:0] br, input logic pcw,
                                       input logic irw, input logic rd,
                                       input logic wr, input logic iord,
                                       input logic trp);
        return {alu, os, we, 1'b0, wds, br, pcw, irw, rd, wr, iord, trp};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check present state and controls, then advance one clock
    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] exp);
        #1;
        check_eq({tag, "/st"}, 32'(state_o), 32'(st));
        check_eq({tag, "/ctl"}, 32'(ctl), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq({tag, "/cause"}, 32'(trap_cause), 32'd0);
        step(tag, 4'd0, 16'h0);
        reset     = 1'b0;
        mem_ready = 1'b0;
    endtask

    logic [15:0] FETCH, FETCH_IR, ZERO;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        FETCH    = mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 1, 0);
        FETCH_IR = mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 1, 1, 0, 1, 0);
        ZERO     = 16'h0;
        reset = 1'b1; opcode = 5'b0; Flag = 1'b0; mem_ready = 1'b0;
        @(posedge clock);
        #1;
        do_reset("rst0");

        // ADD
        opcode = 5'b01100; mem_ready = 1'b1;
        step("add_if", 4'd0, FETCH_IR);
        step("add_id", 4'd1, ZERO);
        step("add_ex", 4'd3, mk(2'b10, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
        step("add_wb", 4'd10, mk(2'b00, 0, 1, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0));
`ifdef MC_FSM_PERF_CNT_EN
        check_eq("add_retire", retire_cnt, 32'd1);
        check_eq("add_cycles", cycle_cnt, 32'd4);
`else
        check_eq("add_retire", retire_cnt, 32'd0);
        check_eq("add_cycles", cycle_cnt, 32'd0);
`endif

        // ADDI
        opcode = 5'b00100;
        step("addi_if", 4'd0, FETCH_IR);
        step("addi_id", 4'd1, ZERO);
        step("addi_ex", 4'd4, mk(2'b10, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
        step("addi_wb", 4'd10, mk(2'b00, 0, 1, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0));

        // LW with three wait states
        opcode = 5'b00000;
        step("lw_if", 4'd0, FETCH_IR);
        step("lw_id", 4'd1, ZERO);
        step("lw_ex", 4'd2, mk(2'b01, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw_wait", 4'd7, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0));
        mem_ready = 1'b1;
        step("lw_mem", 4'd7, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0));
        step("lw_wb", 4'd9, mk(2'b00, 0, 1, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0));

        // BEQ taken, then not taken
        opcode = 5'b11000; Flag = 1'b1;
        step("beq1_if", 4'd0, FETCH_IR);
        step("beq1_id", 4'd1, ZERO);
        step("beq1_ex", 4'd5, mk(2'b11, 0, 0, 3'b000, 2'b01, 1, 0, 0, 0, 0, 0));
        Flag = 1'b0;
        step("beq0_if", 4'd0, FETCH_IR);
        step("beq0_id", 4'd1, ZERO);
        step("beq0_ex", 4'd5, mk(2'b11, 0, 0, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0));

        // JALR, JAL, LUI, AUIPC
        opcode = 5'b11001;
        step("jalr_if", 4'd0, FETCH_IR);
        step("jalr_id", 4'd1, ZERO);
        step("jalr_ex", 4'd12, mk(2'b01, 1, 1, 3'b100, 2'b11, 1, 0, 0, 0, 0, 0));
        opcode = 5'b11011;
        step("jal_if", 4'd0, FETCH_IR);
        step("jal_id", 4'd1, ZERO);
        step("jal_ex", 4'd6, mk(2'b00, 0, 1, 3'b100, 2'b10, 1, 0, 0, 0, 0, 0));
        opcode = 5'b01101;
        step("lui_if", 4'd0, FETCH_IR);
        step("lui_id", 4'd1, ZERO);
        step("lui_wb", 4'd11, mk(2'b00, 0, 1, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0));
        opcode = 5'b00101;
        step("auipc_if", 4'd0, FETCH_IR);
        step("auipc_id", 4'd1, ZERO);
        step("auipc_wb", 4'd11, mk(2'b00, 0, 1, 3'b011, 2'b00, 1, 0, 0, 0, 0, 0));

        // SW with one wait state; PC_Write only when ready
        opcode = 5'b01000;
        step("sw_if", 4'd0, FETCH_IR);
        step("sw_id", 4'd1, ZERO);
        step("sw_ex", 4'd2, mk(2'b01, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        step("sw_wait", 4'd8, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0));
        mem_ready = 1'b1;
        step("sw_mem", 4'd8, mk(2'b00, 0, 0, 3'b000, 2'b00, 1, 0, 0, 1, 0, 0));
        step("sw_done", 4'd0, FETCH_IR);
        step("sw2_id", 4'd1, ZERO);
        step("sw2_ex", 4'd2, mk(2'b01, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));

        // Reset asserted mid-store
        mem_ready = 1'b0;
        step("swr_wait", 4'd8, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0));
        reset = 1'b1;
        step("swr_rst", 4'd0, ZERO);
        reset = 1'b0;
        step("swr_after", 4'd0, FETCH);

        // Illegal opcode trap, sticky against mem_ready
        do_reset("rst1");
        opcode = 5'b11111; mem_ready = 1'b1;
        step("ill_if", 4'd0, FETCH_IR);
        step("ill_id", 4'd1, ZERO);
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            check_eq("ill_cause", 32'(trap_cause), 32'd1);
            step("ill_trap", 4'd13, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1));
        end
        do_reset("rst2");
        #1;
        check_eq("rst2_cause", 32'(trap_cause), 32'd0);
        check_eq("rst2_state", 32'(state_o), 32'd0);

        // Fetch timeout after 15 idle cycles
        opcode = 5'b01100; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            step("to_wait", 4'd0, FETCH);
        #1;
        check_eq("to_cause", 32'(trap_cause), 32'd2);
        step("to_trap", 4'd13, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1));

        // Ready in the 15th cycle wins
        do_reset("rst3");
        for (int i = 0; i < 14; i++)
            step("tr_wait", 4'd0, FETCH);
        mem_ready = 1'b1;
        step("tr_last", 4'd0, FETCH_IR);
        #1;
        check_eq("tr_cause", 32'(trap_cause), 32'd0);
        step("tr_id", 4'd1, ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
